// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS-subset control unit:
// FSM states, instruction classes, opcode/func constants and mux-select codes.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE, S_IF, S_ID, S_EX, S_MEM, S_WB
    } state_t;

    typedef enum logic [3:0] {
        C_ALU_R, C_ALU_I, C_JR, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL, C_ILL
    } iclass_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLTU = 6'b101011;
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_JR   = 6'b001000;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_XOR  = 4'b0010;
    localparam logic [3:0] ALU_NOR  = 4'b0011;
    localparam logic [3:0] ALU_ADD  = 4'b0100;
    localparam logic [3:0] ALU_SUB  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;

    localparam logic [1:0] PC_INC = 2'b00;
    localparam logic [1:0] PC_RS  = 2'b01;
    localparam logic [1:0] PC_BR  = 2'b10;
    localparam logic [1:0] PC_JMP = 2'b11;

    localparam logic [1:0] WR_RD = 2'b00;
    localparam logic [1:0] WR_RT = 2'b01;
    localparam logic [1:0] WR_RA = 2'b10;

    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_MEM = 2'b01;
    localparam logic [1:0] WD_PC4 = 2'b10;

    typedef struct packed {
        iclass_t    cls;
        logic [3:0] alu_op;
        logic       imm_s;
        logic       rt_imm_s;
        logic [1:0] w_r_s;
        logic [1:0] wr_data_s;
        logic       illegal;
    } ctrl_bundle_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder: op/func to a per-instruction control
// bundle. The FSM decides in which state each field actually reaches a pin.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [5:0]   i_op,
    input  logic [5:0]   i_func,
    output ctrl_bundle_t o_ctrl
);

    always_comb begin
        o_ctrl         = '0;
        o_ctrl.cls     = C_ILL;
        o_ctrl.illegal = 1'b1;
        case (i_op)
            OP_RTYPE: begin
                o_ctrl.cls     = C_ALU_R;
                o_ctrl.illegal = 1'b0;
                o_ctrl.w_r_s   = WR_RD;
                case (i_func)
                    FN_ADD:  o_ctrl.alu_op = ALU_ADD;
                    FN_SUB:  o_ctrl.alu_op = ALU_SUB;
                    FN_AND:  o_ctrl.alu_op = ALU_AND;
                    FN_OR:   o_ctrl.alu_op = ALU_OR;
                    FN_XOR:  o_ctrl.alu_op = ALU_XOR;
                    FN_NOR:  o_ctrl.alu_op = ALU_NOR;
                    FN_SLTU: o_ctrl.alu_op = ALU_SLTU;
                    FN_SLL:  o_ctrl.alu_op = ALU_SLL;
                    FN_JR:   o_ctrl.cls    = C_JR;
                    default: begin
                        o_ctrl.cls     = C_ILL;
                        o_ctrl.illegal = 1'b1;
                    end
                endcase
            end
            OP_ADDI, OP_ANDI, OP_XORI, OP_SLTIU: begin
                o_ctrl.cls      = C_ALU_I;
                o_ctrl.illegal  = 1'b0;
                o_ctrl.rt_imm_s = 1'b1;
                o_ctrl.w_r_s    = WR_RT;
                case (i_op)
                    OP_ADDI: begin
                        o_ctrl.alu_op = ALU_ADD;
                        o_ctrl.imm_s  = 1'b1;
                    end
                    OP_ANDI: o_ctrl.alu_op = ALU_AND;
                    OP_XORI: o_ctrl.alu_op = ALU_XOR;
                    default: o_ctrl.alu_op = ALU_SLTU;
                endcase
            end
            OP_LW, OP_SW: begin
                o_ctrl.cls       = (i_op == OP_LW) ? C_LW : C_SW;
                o_ctrl.illegal   = 1'b0;
                o_ctrl.alu_op    = ALU_ADD;
                o_ctrl.imm_s     = 1'b1;
                o_ctrl.rt_imm_s  = 1'b1;
                o_ctrl.w_r_s     = WR_RT;
                o_ctrl.wr_data_s = WD_MEM;
            end
            // Branch offsets are signed, so imm_s stays set for the target adder.
            OP_BEQ, OP_BNE: begin
                o_ctrl.cls     = (i_op == OP_BEQ) ? C_BEQ : C_BNE;
                o_ctrl.illegal = 1'b0;
                o_ctrl.alu_op  = ALU_SUB;
                o_ctrl.imm_s   = 1'b1;
            end
            OP_J: begin
                o_ctrl.cls     = C_J;
                o_ctrl.illegal = 1'b0;
            end
            OP_JAL: begin
                o_ctrl.cls       = C_JAL;
                o_ctrl.illegal   = 1'b0;
                o_ctrl.w_r_s     = WR_RA;
                o_ctrl.wr_data_s = WD_PC4;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle IF/ID/EX/MEM/WB control FSM for the MIPS-subset datapath.
// Optional build macro MEM_TIMEOUT_EN adds a MEM wait counter and mem_fault.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int ALU_OP_W = 4,
    parameter int WAIT_MAX = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [5:0]          op,
    input  logic [5:0]          func,
    input  logic                zf,
    input  logic                mem_ready,
    output logic                ir_write,
    output logic                pc_write,
    output logic [1:0]          pc_s,
    output logic [1:0]          w_r_s,
    output logic                imm_s,
    output logic                rt_imm_s,
    output logic [1:0]          wr_data_s,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                write_reg,
    output logic                mem_read,
    output logic                mem_write,
    output logic                illegal,
    output logic                mem_fault
);

    if (ALU_OP_W < 4 || WAIT_MAX < 1 || WAIT_MAX > 255) begin : g_bad_param
        $error("multicycle_ctrl: ALU_OP_W must be >= 4 and WAIT_MAX in 1..255");
    end

    state_t       r_state;
    logic [5:0]   r_op;
    logic [5:0]   r_func;
    logic [5:0]   w_dec_op;
    logic [5:0]   w_dec_func;
    logic         w_timeout;
    ctrl_bundle_t w_ctrl;

    // ID decodes the live IR fields; later states only see the latched copy.
    assign w_dec_op   = (r_state == S_ID) ? op   : r_op;
    assign w_dec_func = (r_state == S_ID) ? func : r_func;

    ctrl_decode u_decode (
        .i_op   (w_dec_op),
        .i_func (w_dec_func),
        .o_ctrl (w_ctrl)
    );

`ifdef MEM_TIMEOUT_EN
    logic [7:0] r_wait;
    assign w_timeout = (r_state == S_MEM) && !mem_ready && (r_wait == 8'(WAIT_MAX));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_func  <= '0;
`ifdef MEM_TIMEOUT_EN
            r_wait  <= '0;
`endif
        end else begin
`ifdef MEM_TIMEOUT_EN
            if (r_state == S_MEM && !mem_ready && !w_timeout)
                r_wait <= r_wait + 8'd1;
            else
                r_wait <= '0;
`endif
            case (r_state)
                S_IDLE: r_state <= S_IF;
                S_IF:   r_state <= S_ID;
                S_ID: begin
                    r_op   <= op;
                    r_func <= func;
                    case (w_ctrl.cls)
                        C_J, C_ILL: r_state <= S_IF;
                        C_JAL:      r_state <= S_WB;
                        default:    r_state <= S_EX;
                    endcase
                end
                S_EX: begin
                    case (w_ctrl.cls)
                        C_BEQ, C_BNE, C_JR: r_state <= S_IF;
                        C_LW, C_SW:         r_state <= S_MEM;
                        default:            r_state <= S_WB;
                    endcase
                end
                // Ready has priority over a coincident timeout.
                S_MEM: begin
                    if (mem_ready)
                        r_state <= (w_ctrl.cls == C_LW) ? S_WB : S_IF;
                    else if (w_timeout)
                        r_state <= S_IF;
                end
                S_WB:    r_state <= S_IF;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_s      = PC_INC;
        w_r_s     = WR_RD;
        imm_s     = 1'b0;
        rt_imm_s  = 1'b0;
        wr_data_s = WD_ALU;
        alu_op    = '0;
        write_reg = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        illegal   = 1'b0;
        mem_fault = 1'b0;
        case (r_state)
            S_IF: begin
                ir_write = 1'b1;
                pc_write = 1'b1;
            end
            S_ID: begin
                illegal = w_ctrl.illegal;
                if (w_ctrl.cls == C_J) begin
                    pc_write = 1'b1;
                    pc_s     = PC_JMP;
                end
            end
            S_EX: begin
                alu_op[3:0] = w_ctrl.alu_op;
                imm_s       = w_ctrl.imm_s;
                rt_imm_s    = w_ctrl.rt_imm_s;
                case (w_ctrl.cls)
                    C_BEQ: begin
                        pc_write = zf;
                        pc_s     = PC_BR;
                    end
                    C_BNE: begin
                        pc_write = !zf;
                        pc_s     = PC_BR;
                    end
                    C_JR: begin
                        pc_write = 1'b1;
                        pc_s     = PC_RS;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                alu_op[3:0] = w_ctrl.alu_op;
                imm_s       = w_ctrl.imm_s;
                rt_imm_s    = w_ctrl.rt_imm_s;
                mem_read    = (w_ctrl.cls == C_LW);
                mem_write   = (w_ctrl.cls == C_SW);
                mem_fault   = w_timeout;
            end
            S_WB: begin
                alu_op[3:0] = w_ctrl.alu_op;
                imm_s       = w_ctrl.imm_s;
                rt_imm_s    = w_ctrl.rt_imm_s;
                write_reg   = 1'b1;
                w_r_s       = w_ctrl.w_r_s;
                wr_data_s   = w_ctrl.wr_data_s;
                if (w_ctrl.cls == C_JAL) begin
                    pc_write = 1'b1;
                    pc_s     = PC_JMP;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-instruction expected cycle traces
// are queued by the stimulus and checked by an independent negedge monitor.
module tb_multicycle_ctrl;

    localparam int WAIT_MAX = 15;

    logic       clk = 1'b0;
    logic       rst_n, zf, mem_ready;
    logic [5:0] op, func;
    logic       ir_write, pc_write, imm_s, rt_imm_s, write_reg;
    logic       mem_read, mem_write, illegal, mem_fault;
    logic [1:0] pc_s, w_r_s, wr_data_s;
    logic [3:0] alu_op;

    always #5 clk = ~clk;

    multicycle_ctrl #(.ALU_OP_W(4), .WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .func(func), .zf(zf),
        .mem_ready(mem_ready), .ir_write(ir_write), .pc_write(pc_write),
        .pc_s(pc_s), .w_r_s(w_r_s), .imm_s(imm_s), .rt_imm_s(rt_imm_s),
        .wr_data_s(wr_data_s), .alu_op(alu_op), .write_reg(write_reg),
        .mem_read(mem_read), .mem_write(mem_write), .illegal(illegal),
        .mem_fault(mem_fault)
    );

    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_s;
        logic [1:0] w_r_s;
        logic       imm_s;
        logic       rt_imm_s;
        logic [1:0] wr_data_s;
        logic [3:0] alu_op;
        logic       write_reg;
        logic       mem_read;
        logic       mem_write;
        logic       illegal;
        logic       mem_fault;
    } vec_t;

    typedef enum {K_R, K_I, K_JR, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JAL, K_ILL} kind_t;

    vec_t  act;
    vec_t  exp_q[$];
    string name_q[$];
    int    total = 0;
    int    bad   = 0;

    logic [5:0] ops_tab [0:10] = '{6'b000000, 6'b001000, 6'b001100, 6'b001110,
                                   6'b001011, 6'b100011, 6'b101011, 6'b000100,
                                   6'b000101, 6'b000010, 6'b000011};
    logic [5:0] fns_tab [0:8]  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                   6'b100110, 6'b100111, 6'b101011, 6'b000000,
                                   6'b001000};

    assign act = {ir_write, pc_write, pc_s, w_r_s, imm_s, rt_imm_s, wr_data_s,
                  alu_op, write_reg, mem_read, mem_write, illegal, mem_fault};

    function automatic kind_t kind_of(input logic [5:0] o, input logic [5:0] f);
        case (o)
            6'b000000: begin
                if (f == 6'b001000) return K_JR;
                for (int i = 0; i < 8; i++)
                    if (fns_tab[i] == f) return K_R;
                return K_ILL;
            end
            6'b001000, 6'b001100, 6'b001110, 6'b001011: return K_I;
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            6'b000100: return K_BEQ;
            6'b000101: return K_BNE;
            6'b000010: return K_J;
            6'b000011: return K_JAL;
            default:   return K_ILL;
        endcase
    endfunction

    function automatic logic [3:0] alu_of(input kind_t k, input logic [5:0] o, input logic [5:0] f);
        if (k == K_R) begin
            case (f)
                6'b100000: return 4'd4;
                6'b100010: return 4'd5;
                6'b100100: return 4'd0;
                6'b100101: return 4'd1;
                6'b100110: return 4'd2;
                6'b100111: return 4'd3;
                6'b101011: return 4'd6;
                default:   return 4'd7;
            endcase
        end
        if (k == K_I) begin
            case (o)
                6'b001000: return 4'd4;
                6'b001100: return 4'd0;
                6'b001110: return 4'd2;
                default:   return 4'd6;
            endcase
        end
        if (k == K_LW || k == K_SW) return 4'd4;
        if (k == K_BEQ || k == K_BNE) return 4'd5;
        return 4'd0;
    endfunction

    initial begin : monitor
        vec_t  e;
        string n;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                total++;
                if (act !== e) begin
                    bad++;
                    $display("FAIL %s: actual=%h expected=%h", n, act, e);
                end
            end
        end
    end

    task automatic idle_cycle(input string nm, input logic rst);
        @(posedge clk); #1;
        rst_n = rst; mem_ready = 1'b0; zf = 1'($urandom);
        op = 6'($urandom); func = 6'($urandom);
        exp_q.push_back('0); name_q.push_back(nm);
    endtask

    // Builds the expected per-cycle trace of one instruction from the opcode
    // table, then drives it; abort_at >= 0 pulls reset in that cycle.
    task automatic run_instr(input string nm, input logic [5:0] o, input logic [5:0] f,
                             input logic z, input int w, input int abort_at);
        kind_t k = kind_of(o, f);
        vec_t  ex, v;
        vec_t  seq[$];
        string tag[$];
        int    rdy_at = -1;
        int    n_mem = w + 1;
        logic  fault = 1'b0;

        ex = '0;
        ex.alu_op   = alu_of(k, o, f);
        ex.imm_s    = (k == K_LW || k == K_SW || k == K_BEQ || k == K_BNE || (k == K_I && o == 6'b001000));
        ex.rt_imm_s = (k == K_I || k == K_LW || k == K_SW);

        v = '0; v.ir_write = 1'b1; v.pc_write = 1'b1;
        seq.push_back(v); tag.push_back("IF");

        v = '0;
        if (k == K_J) begin v.pc_write = 1'b1; v.pc_s = 2'b11; end
        if (k == K_ILL) v.illegal = 1'b1;
        seq.push_back(v); tag.push_back("ID");

        if (k inside {K_R, K_I, K_JR, K_LW, K_SW, K_BEQ, K_BNE}) begin
            v = ex;
            if (k == K_BEQ) begin v.pc_write = z;  v.pc_s = 2'b10; end
            if (k == K_BNE) begin v.pc_write = !z; v.pc_s = 2'b10; end
            if (k == K_JR)  begin v.pc_write = 1'b1; v.pc_s = 2'b01; end
            seq.push_back(v); tag.push_back("EX");
        end

        if (k == K_LW || k == K_SW) begin
`ifdef MEM_TIMEOUT_EN
            if (w > WAIT_MAX) begin n_mem = WAIT_MAX + 1; fault = 1'b1; end
`endif
            for (int m = 0; m < n_mem; m++) begin
                v = ex;
                v.mem_read  = (k == K_LW);
                v.mem_write = (k == K_SW);
                v.mem_fault = fault && (m == n_mem - 1);
                seq.push_back(v); tag.push_back("MEM");
            end
            if (!fault) rdy_at = seq.size() - 1;
        end

        if (k == K_R || k == K_I || k == K_JAL || (k == K_LW && !fault)) begin
            if (k == K_JAL) v = '0; else v = ex;
            v.write_reg = 1'b1;
            v.w_r_s     = (k == K_R) ? 2'b00 : (k == K_JAL) ? 2'b10 : 2'b01;
            v.wr_data_s = (k == K_LW) ? 2'b01 : (k == K_JAL) ? 2'b10 : 2'b00;
            if (k == K_JAL) begin v.pc_write = 1'b1; v.pc_s = 2'b11; end
            seq.push_back(v); tag.push_back("WB");
        end

        for (int i = 0; i < seq.size(); i++) begin
            @(posedge clk); #1;
            op        = (i == 1) ? o : 6'($urandom);
            func      = (i == 1) ? f : 6'($urandom);
            zf        = (tag[i] == "EX") ? z : 1'($urandom);
            mem_ready = (i == rdy_at);
            rst_n     = (i != abort_at);
            exp_q.push_back(seq[i]);
            name_q.push_back({nm, ".", tag[i]});
            if (i == abort_at) begin
                idle_cycle({nm, ".abort_idle"}, 1'b1);
                return;
            end
        end
    endtask

    initial begin : stim
        logic [5:0] ro, rf;
        rst_n = 1'b0; op = '0; func = '0; zf = 1'b0; mem_ready = 1'b0;
        idle_cycle("reset_hold", 1'b0);
        idle_cycle("reset_idle", 1'b1);

        run_instr("add",      6'b000000, 6'b100000, 1'b0, 0, -1);
        run_instr("lw_w2",    6'b100011, 6'b000000, 1'b0, 2, -1);
        run_instr("beq_z1",   6'b000100, 6'b000000, 1'b1, 0, -1);
        run_instr("beq_z0",   6'b000100, 6'b000000, 1'b0, 0, -1);
        run_instr("bne_z1",   6'b000101, 6'b000000, 1'b1, 0, -1);
        run_instr("bne_z0",   6'b000101, 6'b000000, 1'b0, 0, -1);
        run_instr("jal",      6'b000011, 6'b000000, 1'b0, 0, -1);
        run_instr("ill_op",   6'b111111, 6'b100000, 1'b0, 0, -1);
        run_instr("ill_func", 6'b000000, 6'b000001, 1'b0, 0, -1);
        run_instr("j",        6'b000010, 6'b000000, 1'b0, 0, -1);
        run_instr("jr",       6'b000000, 6'b001000, 1'b0, 0, -1);
        run_instr("sw_w0",    6'b101011, 6'b000000, 1'b0, 0, -1);
        run_instr("sll",      6'b000000, 6'b000000, 1'b0, 0, -1);
        run_instr("sltiu",    6'b001011, 6'b000000, 1'b0, 0, -1);

        for (int n = 0; n < 300; n++) begin
            int sel = $urandom_range(0, 15);
            ro = ops_tab[$urandom_range(0, 10)];
            rf = (ro == 6'b000000) ? fns_tab[$urandom_range(0, 8)] : 6'($urandom);
            if (sel == 0) begin ro = 6'($urandom); rf = 6'($urandom); end
            if (sel == 1 && ro == 6'b000000) rf = 6'($urandom);
            run_instr("rand", ro, rf, 1'($urandom), $urandom_range(0, 3), -1);
        end

        run_instr("lw_abort", 6'b100011, 6'b000000, 1'b0, 5, 4);
        run_instr("add_post", 6'b000000, 6'b100010, 1'b0, 0, -1);
`ifdef MEM_TIMEOUT_EN
        run_instr("sw_tmo",   6'b101011, 6'b000000, 1'b0, WAIT_MAX + 2, -1);
        run_instr("lw_edge",  6'b100011, 6'b000000, 1'b0, WAIT_MAX, -1);
        run_instr("add_tmo",  6'b000000, 6'b100000, 1'b0, 0, -1);
`endif

        @(negedge clk); #1;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: actual=%0d expected=0 entries left", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control unit for the R/I/J MIPS-subset CPU. It replaces the single-cycle combinational decoder with a state machine that spreads each instruction over 2–5 cycles (IF/ID/EX/MEM/WB). It drives the same datapath mux selects, plus IR/PC write enables and a memory request/ready handshake. It sits between the instruction register and the datapath, and resolves branches from the ALU zero flag in EX.

## Interface

Parameters:
- ALU_OP_W, 4, width of alu_op.
- WAIT_MAX, 15, maximum MEM wait cycles before fault (range 1..255).

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- op  in  6  opcode field of the instruction register.
- func  in  6  function field of the instruction register.
- zf  in  1  ALU zero flag, valid in EX.
- mem_ready  in  1  data memory completes the access this cycle.
- ir_write  out  1  load IR.
- pc_write  out  1  load PC from the pc_s-selected source.
- pc_s  out  2  PC source: 00 pc+4, 01 rs (jr), 10 branch target, 11 jump target.
- w_r_s  out  2  write register select: 00 rd, 01 rt, 10 $31.
- imm_s  out  1  1 = sign-extend immediate, 0 = zero-extend.
- rt_imm_s  out  1  ALU B input: 0 = rt, 1 = immediate.
- wr_data_s  out  2  write-back data: 00 ALU, 01 memory, 10 pc+4.
- alu_op  out  ALU_OP_W  ALU op: 0000 and, 0001 or, 0010 xor, 0011 nor, 0100 add, 0101 sub, 0110 sltu, 0111 sll. Upper bits are zero when ALU_OP_W > 4.
- write_reg  out  1  register file write enable.
- mem_read  out  1  data memory read request.
- mem_write  out  1  data memory write request.
- illegal  out  1  one-cycle pulse: unsupported opcode/func.
- mem_fault  out  1  one-cycle pulse: MEM wait timeout.

## Operation

- States: IDLE, IF, ID, EX, MEM, WB.
- op/func are latched into internal registers on the ID edge. EX/MEM/WB decode only the latched copy.
- IDLE:
  - All outputs 0.
  - Goes to IF on the first cycle with rst_n=1.
- IF:
  - ir_write=1, pc_write=1, pc_s=00.
  - Always goes to ID.
- ID:
  - Decodes the instruction and goes to its next state:
    - j: pc_write=1, pc_s=11, next IF.
    - jal: next WB.
    - Illegal: illegal=1, next IF.
    - All others: next EX.
- EX:
  - alu_op, imm_s, rt_imm_s are driven per instruction:
    - add 0100, sub 0101, and 0000, or 0001, xor 0010, nor 0011, sltu 0110, sll 0111.
    - addi: add, imm_s=1.
    - andi: and, imm_s=0.
    - xori: xor, imm_s=0.
    - sltiu: sltu, imm_s=0.
    - lw/sw: add, imm_s=1.
    - beq/bne: sub.
  - beq: pc_write=zf, pc_s=10. bne: pc_write=!zf, pc_s=10. Next IF.
  - jr (R, func 001000): pc_write=1, pc_s=01, write_reg=0, next IF.
  - lw/sw: next MEM.
  - All others: next WB.
  - ALU controls stay asserted through MEM/WB of the same instruction.
- MEM:
  - lw asserts mem_read; sw asserts mem_write.
  - The request is held until mem_ready=1 is sampled.
  - On ready: lw goes to WB, sw goes to IF.
- WB:
  - write_reg=1 for one cycle, then IF.
  - w_r_s: R-type 00; I-type and lw 01; jal 10.
  - wr_data_s: ALU 00; lw 01; jal 10.
  - jal additionally drives pc_write=1, pc_s=11 in WB.
- Illegal: any opcode outside {000000, 001000, 001100, 001110, 001011, 100011, 101011, 000100, 000101, 000010, 000011}, or an R-type func outside the listed eight plus jr.
- Cycles per instruction: j 2; beq/bne/jr/jal 3; R/I ALU 4; sw 4+w; lw 5+w (w = wait cycles).

## Timing

- All outputs are combinational from the state register, the latched op/func, zf and mem_ready. There are no output registers.
- Reset (rst_n=0 sampled):
  - State goes to IDLE.
  - Latched op/func clear to 0.
  - Wait counter clears.
  - Every output is 0 in the following cycle.
- Reset mid-instruction (including MEM with a request pending) aborts immediately. The memory request drops on the next cycle.
- zf is sampled only in EX of beq/bne.
- Handshake: mem_ready must not be asserted outside MEM; it is ignored there. mem_ready=1 in the first MEM cycle means zero wait.

## Configuration

- MEM_TIMEOUT_EN defined:
  - An 8-bit wait counter increments on each MEM cycle with mem_ready=0.
  - When the count equals WAIT_MAX with mem_ready still 0, the FSM asserts mem_fault for that cycle, drops the request and goes to IF. It skips WB.
  - If mem_ready and the timeout coincide, ready wins.
- Undefined: no counter; MEM waits indefinitely and mem_fault is tied 0.

## Structure

- Shared package ctrl_pkg:
  - state enum.
  - opcode and func constants.
  - ALU op codes.
  - pc_s, w_r_s and wr_data_s encodings.
- One natural sub-module, ctrl_decode: combinational mapping from latched op/func to a per-instruction control bundle (class, ALU op, mux selects, illegal). The FSM in multicycle_ctrl gates that bundle by state.

## Test plan

- Reset then add (op 000000, func 100000): IDLE, IF, ID, EX, WB. EX alu_op=0100; WB write_reg=1, w_r_s=00, wr_data_s=00. Next IF after 4 cycles.
- lw with mem_ready low 2 cycles: mem_read high for 3 MEM cycles, then WB with wr_data_s=01, w_r_s=01. 7 cycles total.
- beq with zf=1 → EX pc_write=1, pc_s=10. beq with zf=0 → pc_write=0. bne inverted. Each takes 3 cycles.
- jal: ID→WB; WB has write_reg=1, w_r_s=10, wr_data_s=10, pc_write=1, pc_s=11.
- op 111111, then R func 000001: each gives illegal=1 in ID, no write_reg/mem_write, next IF.
- MEM_TIMEOUT_EN, WAIT_MAX=3, sw with mem_ready held 0: mem_fault at the 4th MEM cycle, then IF. A separate run asserts rst_n=0 during MEM: IDLE next with all outputs 0.
